// File: rtl/dispense_sequencer_if.sv
// Purpose: bundles the dispense_sequencer control and emitter-side signals.
// Ports:   start/abort/amt0..2 request a recipe; cnt_done returns emitter completion;
//          ld/amt_out/en drive the emitters; cur_ch/busy/done/timeout_err report status.
// Modports: master = user FSM + emitters (drives requests), slave = the sequencer.
interface dispense_sequencer_if #(
  parameter int W = 8
);
  logic         start;
  logic         abort;
  logic [W-1:0] amt0;
  logic [W-1:0] amt1;
  logic [W-1:0] amt2;
  logic [2:0]   cnt_done;
  logic [2:0]   ld;
  logic [W-1:0] amt_out;
  logic [2:0]   en;
  logic [1:0]   cur_ch;
  logic         busy;
  logic         done;
  logic         timeout_err;

  modport master (
    output start, abort, amt0, amt1, amt2, cnt_done,
    input  ld, amt_out, en, cur_ch, busy, done, timeout_err
  );

  modport slave (
    input  start, abort, amt0, amt1, amt2, cnt_done,
    output ld, amt_out, en, cur_ch, busy, done, timeout_err
  );
endinterface

// File: rtl/dispense_sequencer.sv
// Purpose: latches a 3-channel pour recipe and services one emitter channel at a time
//          (load strobe, enable, completion wait, per-channel timeout, break-before-make gap).
// Ports:   clk, RESET (sync, active-high); bus (slave modport) carries start/abort/amounts,
//          cnt_done in, and ld/amt_out/en/cur_ch/busy/done/timeout_err out (all registered).
module dispense_sequencer #(
  parameter int W       = 8,
  parameter int TIMEOUT = 1000,
  parameter int TW      = 10
) (
  input  logic                  clk,
  input  logic                  RESET,
  dispense_sequencer_if.slave   bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_LOAD,
    S_RUN,
    S_GAP,
    S_DONE,
    S_ERR
  } state_t;

  typedef struct packed {
    logic [2:0]   ld;
    logic [W-1:0] amt_out;
    logic [2:0]   en;
    logic [1:0]   cur_ch;
    logic         busy;
    logic         done;
    logic         timeout_err;
  } out_t;

  state_t       state;
  logic [1:0]   ch;      // value 3 means every channel has been visited
  logic [TW-1:0] timer;
  logic [W-1:0] amt_reg0;
  logic [W-1:0] amt_reg1;
  logic [W-1:0] amt_reg2;
  out_t         outs;

  logic [W-1:0] amt_cur;
  logic         ch_done;

  // Outputs are registered: every transition loads the Moore decode of the
  // state being entered, so the ports always match the registered state.
  function automatic out_t decode(state_t s, logic [1:0] c, logic [W-1:0] a);
    out_t o;
    o        = '0;
    o.busy   = (s != S_IDLE);
    o.cur_ch = (s == S_IDLE) ? 2'd0 : c;
    case (s)
      S_LOAD: begin
        o.ld      = 3'b001 << c;
        o.amt_out = a;
      end
      S_RUN:   o.en          = 3'b001 << c;
      S_DONE:  o.done        = 1'b1;
      S_ERR:   o.timeout_err = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  always_comb begin
    amt_cur = '0;
    case (ch)
      2'd0:    amt_cur = amt_reg0;
      2'd1:    amt_cur = amt_reg1;
      2'd2:    amt_cur = amt_reg2;
      default: amt_cur = '0;
    endcase
  end

  // Only the completion bit of the channel being serviced matters.
  assign ch_done = |(bus.cnt_done & (3'b001 << ch));

  always_ff @(posedge clk) begin
    if (RESET) begin
      state    <= S_IDLE;
      ch       <= 2'd0;
      timer    <= '0;
      amt_reg0 <= '0;
      amt_reg1 <= '0;
      amt_reg2 <= '0;
      outs     <= '0;
    end else if (bus.abort && (state != S_IDLE)) begin
      // abort outranks completion and timeout in every active state
      state <= S_IDLE;
      ch    <= 2'd0;
      outs  <= decode(S_IDLE, 2'd0, '0);
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            amt_reg0 <= bus.amt0;
            amt_reg1 <= bus.amt1;
            amt_reg2 <= bus.amt2;
            ch       <= 2'd0;
            state    <= S_SELECT;
            outs     <= decode(S_SELECT, 2'd0, '0);
          end
        end
        S_SELECT: begin
          if (ch == 2'd3) begin
            state <= S_DONE;
            outs  <= decode(S_DONE, ch, '0);
          end else if (amt_cur == '0) begin
            ch   <= ch + 2'd1;
            outs <= decode(S_SELECT, ch + 2'd1, '0);
          end else begin
            state <= S_LOAD;
            outs  <= decode(S_LOAD, ch, amt_cur);
          end
        end
        S_LOAD: begin
          timer <= '0;
          state <= S_RUN;
          outs  <= decode(S_RUN, ch, '0);
        end
        S_RUN: begin
          // completion on the terminal timer cycle still counts as success
          if (ch_done) begin
            state <= S_GAP;
            outs  <= decode(S_GAP, ch, '0);
          end else if (timer == TW'(TIMEOUT - 1)) begin
            state <= S_ERR;
            outs  <= decode(S_ERR, ch, '0);
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_GAP: begin
          ch    <= ch + 2'd1;
          state <= S_SELECT;
          outs  <= decode(S_SELECT, ch + 2'd1, '0);
        end
        S_DONE: begin
          state <= S_IDLE;
          outs  <= decode(S_IDLE, 2'd0, '0);
        end
        S_ERR: begin
          // held until abort, which is handled above
          outs <= decode(S_ERR, ch, '0);
        end
        default: begin
          state <= S_IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

  assign bus.ld          = outs.ld;
  assign bus.amt_out     = outs.amt_out;
  assign bus.en          = outs.en;
  assign bus.cur_ch      = outs.cur_ch;
  assign bus.busy        = outs.busy;
  assign bus.done        = outs.done;
  assign bus.timeout_err = outs.timeout_err;

endmodule

// File: doc/dispense_sequencer.md
Name: dispense_sequencer

Overview:
Central scheduler for the three emitter channels of the dispenser. It latches a per-channel pour recipe, then loads and enables one channel at a time, so only one valve/pump output is ever active. It waits for each channel's completion handshake and enforces a per-channel timeout. It sits between the top-level user FSM (start/abort) and the emitter channel blocks.

Parameters:
W, 8, width of each channel amount (loaded into the emitter counter)
TIMEOUT, 1000, max RUN cycles per channel before error
TW, 10, timer width; must satisfy 2^TW >= TIMEOUT

Ports:
clk  in  1  system clock, rising edge
RESET  in  1  synchronous, active-high reset
start  in  1  one-cycle request to begin a recipe; ignored unless IDLE
abort  in  1  cancel the current recipe or clear an error
amt0  in  W  channel 0 amount, sampled on accepted start
amt1  in  W  channel 1 amount, sampled on accepted start
amt2  in  W  channel 2 amount, sampled on accepted start
cnt_done  in  3  per-channel completion flag from the emitters
ld  out  3  one-hot, one-cycle load strobe to the emitters
amt_out  out  W  amount to load; valid whenever ld != 0, otherwise 0
en  out  3  one-hot emit enable (out_ctrl) for the active channel
cur_ch  out  2  index of the channel being serviced; 0 in IDLE
busy  out  1  high in any state except IDLE
done  out  1  one-cycle pulse when the recipe completes
timeout_err  out  1  held high in ERR

Behaviour:
- Synchronous active-high RESET gives state=IDLE, ch=0, timer=0, amount regs=0. All outputs read 0.
- Outputs are Moore, decoded from registered state, ch and amount regs.
- States: IDLE, SELECT, LOAD, RUN, GAP, DONE, ERR.
- IDLE: start=1 latches amt0..2, sets ch=0, and moves to SELECT.
- SELECT:
  - ch==3 -> DONE.
  - amt_reg[ch]==0 -> ch++ and stay in SELECT (one cycle per skipped channel).
  - otherwise -> LOAD.
- LOAD: ld[ch]=1 and amt_out=amt_reg[ch] for exactly one cycle; timer cleared; -> RUN.
- RUN:
  - en[ch]=1 and timer increments each cycle.
  - cnt_done[ch]=1 -> GAP.
  - Else timer==TIMEOUT-1 -> ERR, so en is high for exactly TIMEOUT cycles.
  - cnt_done together with the terminal timer count: done wins, go to GAP.
- GAP: en=0 for one cycle (break-before-make); ch++ -> SELECT.
- DONE: done=1 for one cycle -> IDLE.
- ERR: en=0, ld=0, timeout_err=1 and cur_ch holds the failing channel. Stays in ERR until abort -> IDLE. start is ignored in ERR.
- abort in any non-IDLE state: next state is IDLE; ld/en are 0 from the next cycle; no done pulse. abort has priority over cnt_done and timeout.
- cnt_done bits for non-active channels, and any cnt_done outside RUN, are ignored.
- start while busy is ignored. Amount inputs are not re-sampled mid-recipe.
- RESET mid-RUN: en drops on the next cycle and all state clears.
- Latency: start at cycle T gives ld at T+2 when amt0!=0. All-zero recipe gives done at T+5.

Test Plan:
- Reset: RESET=1 for 2 cycles with cnt_done=3'b111 -> all outputs 0, busy=0.
- Normal with skip: amt=(5,0,3), start@0 -> ld=001/amt_out=5 @2; en=001 @3..; cnt_done[0]@10 -> en=0 @11; ld=100/amt_out=3 @14; cnt_done[2]@20 -> done=1 @23; busy=0 @24.
- All-zero recipe: amt=(0,0,0), start@0 -> no ld/en; done=1 @5.
- Timeout with TIMEOUT=16: amt0=4, no cnt_done -> en=001 @3..18; timeout_err=1 @19 and held; abort@25 -> IDLE @26, timeout_err=0.
- Abort and ignored events:
  - abort during RUN of ch1 -> en=0 next cycle, no done.
  - start pulsed while busy -> no effect.
  - cnt_done[2] during ch0 RUN -> ignored.
- Simultaneous events:
  - cnt_done[ch] on the timer-terminal cycle -> GAP, no error.
  - abort with cnt_done -> IDLE, no done.
